// File: rtl/dircc_system_states_pkg.sv
// dircc_system_states_pkg: device lifecycle codes and receive-sequencer FSM states
package dircc_system_states_pkg;
  localparam logic [7:0] DIRCC_STATE_RUN     = 8'h01;
  localparam logic [7:0] DIRCC_STATE_DONE    = 8'h02;
  localparam logic [7:0] DIRCC_STATE_STOPPED = 8'h04;
  typedef enum logic [2:0] {
    RX_IDLE,
    RX_READ,
    RX_ISSUE,
    RX_WAIT,
    RX_WRITE
  } rx_seq_state_e;
  function automatic logic dircc_is_finished(input logic [7:0] s);
    return (s & (DIRCC_STATE_DONE | DIRCC_STATE_STOPPED)) != 8'h00;
  endfunction
endpackage

// File: rtl/dircc_types_pkg.sv
// dircc_types_pkg: packet and device-state payload types shared across the DIRCC fabric
package dircc_types_pkg;
  typedef struct packed {
    logic [15:0] src;
    logic [31:0] payload;
  } packet_data_t;
  typedef struct packed {
    logic [7:0]  dircc_state;
    logic [15:0] count;
  } device_state_t;
endpackage

// File: rtl/dircc_sat_counter.sv
// dircc_sat_counter: up-counter that sticks at all-ones
module dircc_sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);
  // count increments until saturated
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) count <= '0;
    else if (inc && count != '1) count <= count + WIDTH'(1);
endmodule

// File: rtl/dircc_receive_sequencer.sv
// dircc_receive_sequencer: one-in-flight RX packet sequencer; DIRCC_RX_TIMEOUT_EN adds a WAIT watchdog
module dircc_receive_sequencer
  import dircc_types_pkg::*;
  import dircc_system_states_pkg::*;
#(
  parameter int ADDRESS_MEM_WIDTH = 32,
  parameter int NUM_DEVICES       = 16
`ifdef DIRCC_RX_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYCLES    = 16
`endif
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  packet_data_t                 pkt_in,
  input  logic [ADDRESS_MEM_WIDTH-1:0] pkt_dst_addr,
  input  logic [7:0]                   pkt_edge_id,
  input  logic [7:0]                   pkt_port_id,
  input  logic                         pkt_valid,
  output logic                         pkt_ready,
  output logic                         state_rd_en,
  output logic [ADDRESS_MEM_WIDTH-1:0] state_rd_addr,
  input  device_state_t                state_rd_data,
  output logic                         state_wr_en,
  output logic [ADDRESS_MEM_WIDTH-1:0] state_wr_addr,
  output device_state_t                state_wr_data,
  output logic [ADDRESS_MEM_WIDTH-1:0] hdl_address,
  output packet_data_t                 hdl_packet,
  output logic                         hdl_packet_valid,
  output logic [7:0]                   hdl_edge_id,
  output logic [7:0]                   hdl_port_id,
  output device_state_t                hdl_read_state,
  output logic                         hdl_receive_done,
  input  device_state_t                hdl_write_state,
  input  logic                         hdl_write_state_valid,
  input  logic                         hdl_packet_handled,
  output logic                         busy,
  output logic [15:0]                  drop_count,
  output logic                         timeout_err
);
  rx_seq_state_e state, state_next;
  logic addr_ok, finished, ack, drop;
  assign addr_ok       = pkt_dst_addr < ADDRESS_MEM_WIDTH'(NUM_DEVICES);
  assign finished      = dircc_is_finished(state_rd_data.dircc_state);
  assign ack           = hdl_write_state_valid && hdl_packet_handled;
  assign state_rd_addr = pkt_dst_addr;
  assign state_wr_addr = hdl_address;
  assign busy          = state != RX_IDLE;
`ifdef DIRCC_RX_TIMEOUT_EN
  localparam int CW = TIMEOUT_CYCLES > 1 ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [CW-1:0] wait_cnt;
  logic expired;
  assign expired = wait_cnt == CW'(TIMEOUT_CYCLES - 1);
  // watchdog counts WAIT cycles from zero; flag sticks until reset
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      wait_cnt    <= '0;
      timeout_err <= 1'b0;
    end else begin
      wait_cnt <= state == RX_WAIT ? wait_cnt + CW'(1) : '0;
      if (state == RX_WAIT && !ack && expired) timeout_err <= 1'b1;
    end
`else
  assign timeout_err = 1'b0;
`endif
  // state register
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state <= RX_IDLE;
    else state <= state_next;
  // next state and per-state strobes
  always_comb begin
    state_next       = state;
    drop             = 1'b0;
    pkt_ready        = 1'b0;
    state_rd_en      = 1'b0;
    hdl_receive_done = 1'b0;
    hdl_packet_valid = 1'b0;
    state_wr_en      = 1'b0;
    case (state)
      RX_IDLE: begin
        pkt_ready   = 1'b1;
        state_rd_en = pkt_valid && addr_ok;
        drop        = pkt_valid && !addr_ok;
        state_next  = state_rd_en ? RX_READ : RX_IDLE;
      end
      RX_READ: begin
        drop       = finished;
        state_next = finished ? RX_IDLE : RX_ISSUE;
      end
      RX_ISSUE: begin
        hdl_receive_done = 1'b1;
        hdl_packet_valid = 1'b1;
        state_next       = RX_WAIT;
      end
      RX_WAIT: begin
        hdl_packet_valid = 1'b1;
`ifdef DIRCC_RX_TIMEOUT_EN
        state_next = ack ? RX_WRITE : expired ? RX_IDLE : RX_WAIT;
`else
        state_next = ack ? RX_WRITE : RX_WAIT;
`endif
      end
      RX_WRITE: begin
        state_wr_en = 1'b1;
        state_next  = RX_IDLE;
      end
      default: state_next = RX_IDLE;
    endcase
  end
  // packet fields latched on accept, old state in READ, handler result on ack
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      hdl_address    <= '0;
      hdl_packet     <= '0;
      hdl_edge_id    <= '0;
      hdl_port_id    <= '0;
      hdl_read_state <= '0;
      state_wr_data  <= '0;
    end else begin
      if (state == RX_IDLE && pkt_valid) begin
        hdl_address <= pkt_dst_addr;
        hdl_packet  <= pkt_in;
        hdl_edge_id <= pkt_edge_id;
        hdl_port_id <= pkt_port_id;
      end
      if (state == RX_READ) hdl_read_state <= state_rd_data;
      if (state == RX_WAIT && ack) state_wr_data <= hdl_write_state;
    end
  dircc_sat_counter #(.WIDTH(16)) u_drop_count (
    .clk    (clk),
    .reset_n(reset_n),
    .inc    (drop),
    .count  (drop_count)
  );
endmodule
